// File: rtl/bp_be_dual_issue_scheduler.sv
// In-order dual-issue scheduler: buffers one decoded pair in two slots (A older,
// B younger), presents their operands to a dual-port scoreboard, and issues
// 0, 1 or 2 instructions per cycle based on hazards and pairing rules.
module bp_be_dual_issue_scheduler #(
    parameter int num_rs_p         = 2,
    parameter int reg_addr_width_p = 5,
    parameter int cnt_width_p      = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    flush_i,
    input  logic                                    pair_v_i,
    output logic                                    pair_ready_o,
    input  logic [1:0]                              instr_v_i,
    input  logic [2*num_rs_p*reg_addr_width_p-1:0]  rs_i,
    input  logic [2*num_rs_p-1:0]                   rs_used_i,
    input  logic [2*reg_addr_width_p-1:0]           rd_i,
    input  logic [1:0]                              rd_w_v_i,
    input  logic [1:0]                              is_mem_i,
    input  logic [1:0]                              is_ctrl_i,
    input  logic [1:0]                              exe_ready_i,
    output logic [num_rs_p*reg_addr_width_p-1:0]    sb_rs_o1,
    output logic [num_rs_p*reg_addr_width_p-1:0]    sb_rs_o2,
    output logic [reg_addr_width_p-1:0]             sb_rd_o1,
    output logic [reg_addr_width_p-1:0]             sb_rd_o2,
    input  logic [num_rs_p-1:0]                     sb_rs_match_i1,
    input  logic [num_rs_p-1:0]                     sb_rs_match_i2,
    input  logic                                    sb_rd_match_i1,
    input  logic                                    sb_rd_match_i2,
    output logic [1:0]                              score_v_o,
    output logic [2*reg_addr_width_p-1:0]           score_rd_o,
    output logic [1:0]                              issue_v_o,
    output logic [1:0]                              issue_slot_idx_o,
    output logic [cnt_width_p-1:0]                  dual_cnt_o,
    output logic [cnt_width_p-1:0]                  single_cnt_o,
    output logic [cnt_width_p-1:0]                  stall_cnt_o
);

    localparam int W    = reg_addr_width_p;
    localparam int RS_W = num_rs_p * reg_addr_width_p;

    // idx remembers which half of the incoming pair the instruction came from
    typedef struct packed {
        logic [RS_W-1:0]     rs;
        logic [num_rs_p-1:0] rs_used;
        logic [W-1:0]        rd;
        logic                rd_w_v;
        logic                is_mem;
        logic                is_ctrl;
        logic                idx;
    } slot_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_e;

    count_e                       count_r;
    slot_t                        slot_a_reg;
    slot_t                        slot_b_reg;
    logic [cnt_width_p-1:0]       dual_cnt_reg;
    logic [cnt_width_p-1:0]       single_cnt_reg;
    logic [cnt_width_p-1:0]       stall_cnt_reg;

    slot_t                        in_slot  [2];
    slot_t                        cur_slot [2];
    logic [1:0]                   slot_v;
    logic [1:0][num_rs_p-1:0]     rs_match;
    logic [1:0]                   rd_match;
    logic [1:0][num_rs_p-1:0]     raw_bits;
    logic [1:0]                   waw;
    logic [1:0]                   hazard;
    logic [1:0]                   rd_nz;
    logic [1:0][W-1:0]            sb_rd_arr;
    logic [1:0][RS_W-1:0]         sb_rs_arr;
    logic                         issue_a;
    logic                         issue_b;
    logic                         drain_all;
    logic                         accept;

    assign cur_slot[0] = slot_a_reg;
    assign cur_slot[1] = slot_b_reg;
    assign slot_v      = {count_r == TWO, count_r != EMPTY};
    assign rs_match[0] = sb_rs_match_i1;
    assign rs_match[1] = sb_rs_match_i2;
    assign rd_match    = {sb_rd_match_i2, sb_rd_match_i1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign in_slot[gi] = '{
                rs:      rs_i[gi*RS_W +: RS_W],
                rs_used: rs_used_i[gi*num_rs_p +: num_rs_p],
                rd:      rd_i[gi*W +: W],
                rd_w_v:  rd_w_v_i[gi],
                is_mem:  is_mem_i[gi],
                is_ctrl: is_ctrl_i[gi],
                idx:     1'(gi)
            };

            // x0 sources never read a pending value
            for (genvar gj = 0; gj < num_rs_p; gj++) begin : g_src
                assign raw_bits[gi][gj] = slot_v[gi]
                                        & cur_slot[gi].rs_used[gj]
                                        & (cur_slot[gi].rs[gj*W +: W] != '0)
                                        & rs_match[gi][gj];
            end

            assign rd_nz[gi]  = cur_slot[gi].rd_w_v & (cur_slot[gi].rd != '0);
            assign waw[gi]    = rd_nz[gi] & rd_match[gi];
            assign hazard[gi] = (|raw_bits[gi]) | waw[gi];

            assign sb_rd_arr[gi] = (slot_v[gi] & rd_nz[gi]) ? cur_slot[gi].rd : '0;
            assign sb_rs_arr[gi] = slot_v[gi] ? cur_slot[gi].rs : '0;

            assign score_v_o[gi]           = issue_v_o[gi] & rd_nz[gi];
            assign score_rd_o[gi*W +: W]   = cur_slot[gi].rd;
            assign issue_slot_idx_o[gi]    = issue_v_o[gi] & cur_slot[gi].idx;
        end
    endgenerate

    assign sb_rs_o1 = sb_rs_arr[0];
    assign sb_rs_o2 = sb_rs_arr[1];
    assign sb_rd_o1 = sb_rd_arr[0];
    assign sb_rd_o2 = sb_rd_arr[1];

    // B pairs with A only when A issues, they do not share the memory port,
    // and A is not a control-flow instruction.
    assign issue_a = slot_v[0] & ~hazard[0] & exe_ready_i[0];
    assign issue_b = issue_a & slot_v[1] & ~hazard[1] & exe_ready_i[1]
                   & ~(slot_a_reg.is_mem & slot_b_reg.is_mem)
                   & ~slot_a_reg.is_ctrl;
    assign issue_v_o = {issue_b, issue_a};

    assign drain_all    = ((count_r == ONE) & issue_a) | ((count_r == TWO) & issue_b);
    assign pair_ready_o = ~flush_i & ((count_r == EMPTY) | drain_all);
    assign accept       = pair_v_i & pair_ready_o;

    assign dual_cnt_o   = dual_cnt_reg;
    assign single_cnt_o = single_cnt_reg;
    assign stall_cnt_o  = stall_cnt_reg;

    // Occupancy FSM, slot loading/shifting, and saturating issue statistics
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r        <= EMPTY;
            slot_a_reg     <= '0;
            slot_b_reg     <= '0;
            dual_cnt_reg   <= '0;
            single_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (count_r != EMPTY) begin
                if (issue_b) begin
                    if (dual_cnt_reg != '1)
                        dual_cnt_reg <= dual_cnt_reg + cnt_width_p'(1);
                end else if (issue_a) begin
                    if (single_cnt_reg != '1)
                        single_cnt_reg <= single_cnt_reg + cnt_width_p'(1);
                end else begin
                    if (stall_cnt_reg != '1)
                        stall_cnt_reg <= stall_cnt_reg + cnt_width_p'(1);
                end
            end

            if (flush_i) begin
                count_r <= EMPTY;
            end else if (accept) begin
                // a new pair replaces whatever just drained
                case (instr_v_i)
                    2'b11: begin
                        count_r    <= TWO;
                        slot_a_reg <= in_slot[0];
                        slot_b_reg <= in_slot[1];
                    end
                    2'b01: begin
                        count_r    <= ONE;
                        slot_a_reg <= in_slot[0];
                    end
                    2'b10: begin
                        count_r    <= ONE;
                        slot_a_reg <= in_slot[1];
                    end
                    default: count_r <= EMPTY;
                endcase
            end else if (count_r == TWO) begin
                if (issue_b) begin
                    count_r <= EMPTY;
                end else if (issue_a) begin
                    count_r    <= ONE;
                    slot_a_reg <= slot_b_reg;
                end
            end else if (count_r == ONE) begin
                if (issue_a)
                    count_r <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_dual_issue_scheduler.sv
// Directed testbench for bp_be_dual_issue_scheduler: a table of single-cycle
// pair scenarios plus hand-written multi-cycle sequences.
module tb_bp_be_dual_issue_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_i, flush_i, pair_v_i, pair_ready_o;
    logic [1:0]  instr_v_i;
    logic [19:0] rs_i;
    logic [3:0]  rs_used_i;
    logic [9:0]  rd_i;
    logic [1:0]  rd_w_v_i, is_mem_i, is_ctrl_i, exe_ready_i;
    logic [9:0]  sb_rs_o1, sb_rs_o2;
    logic [4:0]  sb_rd_o1, sb_rd_o2;
    logic [1:0]  sb_rs_match_i1, sb_rs_match_i2;
    logic        sb_rd_match_i1, sb_rd_match_i2;
    logic [1:0]  score_v_o;
    logic [9:0]  score_rd_o;
    logic [1:0]  issue_v_o, issue_slot_idx_o;
    logic [31:0] dual_cnt_o, single_cnt_o, stall_cnt_o;

    int compared = 0;
    int mismatched = 0;

    bp_be_dual_issue_scheduler dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .pair_v_i(pair_v_i), .pair_ready_o(pair_ready_o), .instr_v_i(instr_v_i),
        .rs_i(rs_i), .rs_used_i(rs_used_i), .rd_i(rd_i), .rd_w_v_i(rd_w_v_i),
        .is_mem_i(is_mem_i), .is_ctrl_i(is_ctrl_i), .exe_ready_i(exe_ready_i),
        .sb_rs_o1(sb_rs_o1), .sb_rs_o2(sb_rs_o2), .sb_rd_o1(sb_rd_o1), .sb_rd_o2(sb_rd_o2),
        .sb_rs_match_i1(sb_rs_match_i1), .sb_rs_match_i2(sb_rs_match_i2),
        .sb_rd_match_i1(sb_rd_match_i1), .sb_rd_match_i2(sb_rd_match_i2),
        .score_v_o(score_v_o), .score_rd_o(score_rd_o),
        .issue_v_o(issue_v_o), .issue_slot_idx_o(issue_slot_idx_o),
        .dual_cnt_o(dual_cnt_o), .single_cnt_o(single_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  iv;
        logic [19:0] rs;     // {B.rs1, B.rs0, A.rs1, A.rs0}
        logic [3:0]  ru;
        logic [9:0]  rd;     // {B.rd, A.rd}
        logic [1:0]  rdw, mem, ctrl, exe, m1, m2, rdm;
        logic [1:0]  e_issue, e_sv;
        logic [9:0]  e_srd;
        logic        e_ready;
        logic [4:0]  e_rd1, e_rd2;
        logic [1:0]  e_idx;
    } vec_t;

    localparam int NV = 15;
    vec_t  vecs  [NV];
    string names [NV];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; pair_v_i = 1'b0; instr_v_i = 2'b00;
        rs_i = '0; rs_used_i = '0; rd_i = '0; rd_w_v_i = '0;
        is_mem_i = '0; is_ctrl_i = '0; exe_ready_i = 2'b11;
        sb_rs_match_i1 = '0; sb_rs_match_i2 = '0;
        sb_rd_match_i1 = 1'b0; sb_rd_match_i2 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Accept vector i's pair into an empty buffer with pipes blocked
    task automatic load_vec(input int i);
        instr_v_i = vecs[i].iv; rs_i = vecs[i].rs; rs_used_i = vecs[i].ru;
        rd_i = vecs[i].rd; rd_w_v_i = vecs[i].rdw; is_mem_i = vecs[i].mem;
        is_ctrl_i = vecs[i].ctrl;
        exe_ready_i = 2'b00; pair_v_i = 1'b1;
        sb_rs_match_i1 = '0; sb_rs_match_i2 = '0;
        sb_rd_match_i1 = 1'b0; sb_rd_match_i2 = 1'b0;
        tick();
        pair_v_i = 1'b0;
    endtask

    initial begin
        //                iv     rs                         ru       rd               rdw    mem    ctrl   exe    m1     m2     rdm    issue  sv     srd              rdy   rd1    rd2    idx
        vecs[0]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, {5'd4,5'd1}, 1'b1, 5'd1, 5'd4, 2'b10}; names[0]  = "indep";
        vecs[1]  = '{2'b11, {5'd2,5'd1,5'd3,5'd2}, 4'b1111, {5'd7,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, {5'd7,5'd1}, 1'b0, 5'd1, 5'd7, 2'b00}; names[1]  = "intra_raw";
        vecs[2]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, {5'd4,5'd1}, 1'b0, 5'd1, 5'd4, 2'b00}; names[2]  = "two_loads";
        vecs[3]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd0}, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, {5'd4,5'd0}, 1'b0, 5'd0, 5'd4, 2'b00}; names[3]  = "branch_a";
        vecs[4]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, {5'd4,5'd1}, 1'b0, 5'd1, 5'd4, 2'b00}; names[4]  = "pipe1_busy";
        vecs[5]  = '{2'b11, 20'd0,                  4'b1111, 10'd0,       2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 10'd0,       1'b1, 5'd0, 5'd0, 2'b10}; names[5]  = "x0";
        vecs[6]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, {5'd4,5'd1}, 1'b0, 5'd1, 5'd4, 2'b00}; names[6]  = "waw_b";
        vecs[7]  = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, {5'd4,5'd1}, 1'b0, 5'd1, 5'd4, 2'b00}; names[7]  = "waw_a";
        vecs[8]  = '{2'b01, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, {5'd4,5'd1}, 1'b1, 5'd1, 5'd0, 2'b00}; names[8]  = "only_slot0";
        vecs[9]  = '{2'b10, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, {5'd0,5'd4}, 1'b1, 5'd4, 5'd0, 2'b01}; names[9]  = "only_slot1";
        vecs[10] = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1100, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, {5'd4,5'd1}, 1'b1, 5'd1, 5'd4, 2'b10}; names[10] = "rs_unused";
        vecs[11] = '{2'b00, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0,       1'b1, 5'd0, 5'd0, 2'b00}; names[11] = "dropped";
        vecs[12] = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, {5'd4,5'd1}, 1'b0, 5'd1, 5'd4, 2'b00}; names[12] = "pipes_busy";
        vecs[13] = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, {5'd4,5'd1}, 1'b1, 5'd1, 5'd4, 2'b10}; names[13] = "ctrl_b";
        vecs[14] = '{2'b11, {5'd6,5'd5,5'd3,5'd2}, 4'b1111, {5'd4,5'd1}, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, {5'd4,5'd1}, 1'b1, 5'd1, 5'd4, 2'b10}; names[14] = "mem_a";

        reset_i = 1'b0;
        do_reset();
        #1;
        // Reset state
        check("rst_issue",  32'(issue_v_o), 32'd0);
        check("rst_score",  32'(score_v_o), 32'd0);
        check("rst_ready",  32'(pair_ready_o), 32'd1);
        check("rst_sbrd1",  32'(sb_rd_o1), 32'd0);
        check("rst_sbrs2",  32'(sb_rs_o2), 32'd0);
        check("rst_dual",   dual_cnt_o, 32'd0);
        check("rst_stall",  stall_cnt_o, 32'd0);

        // Table-driven single-cycle issue decisions
        for (int i = 0; i < NV; i++) begin
            logic [9:0] mask;
            logic [9:0] e_rs1, e_rs2;
            load_vec(i);
            exe_ready_i = vecs[i].exe;
            sb_rs_match_i1 = vecs[i].m1;
            sb_rs_match_i2 = vecs[i].m2;
            sb_rd_match_i1 = vecs[i].rdm[0];
            sb_rd_match_i2 = vecs[i].rdm[1];
            #1;
            mask  = {{5{vecs[i].e_sv[1]}}, {5{vecs[i].e_sv[0]}}};
            e_rs1 = (vecs[i].iv == 2'b00) ? 10'd0 :
                    (vecs[i].iv == 2'b10) ? vecs[i].rs[19:10] : vecs[i].rs[9:0];
            e_rs2 = (vecs[i].iv == 2'b11) ? vecs[i].rs[19:10] : 10'd0;
            $display("vec %0d %s: issue=%b score_v=%b ready=%b", i, names[i], issue_v_o, score_v_o, pair_ready_o);
            check({names[i], ".issue"},    32'(issue_v_o), 32'(vecs[i].e_issue));
            check({names[i], ".score_v"},  32'(score_v_o), 32'(vecs[i].e_sv));
            check({names[i], ".score_rd"}, 32'(score_rd_o & mask), 32'(vecs[i].e_srd & mask));
            check({names[i], ".ready"},    32'(pair_ready_o), 32'(vecs[i].e_ready));
            check({names[i], ".sb_rd1"},   32'(sb_rd_o1), 32'(vecs[i].e_rd1));
            check({names[i], ".sb_rd2"},   32'(sb_rd_o2), 32'(vecs[i].e_rd2));
            check({names[i], ".sb_rs1"},   32'(sb_rs_o1), 32'(e_rs1));
            check({names[i], ".sb_rs2"},   32'(sb_rs_o2), 32'(e_rs2));
            check({names[i], ".idx"},      32'(issue_slot_idx_o), 32'(vecs[i].e_idx));
            flush_i = 1'b1;
            tick();
            idle_inputs();
        end

        // Dual issue with a new pair accepted in the same cycle, then a flush
        do_reset();
        load_vec(0);
        exe_ready_i = 2'b11;
        pair_v_i = 1'b1; instr_v_i = 2'b11; rd_i = {5'd9, 5'd8};
        #1;
        check("seq_dual.issue", 32'(issue_v_o), 32'b11);
        check("seq_dual.ready", 32'(pair_ready_o), 32'd1);
        tick();
        pair_v_i = 1'b0;
        #1;
        $display("seq_dual: dual_cnt=%0d sb_rd1=%0d sb_rd2=%0d", dual_cnt_o, sb_rd_o1, sb_rd_o2);
        check("seq_dual.dual_cnt", dual_cnt_o, 32'd1);
        check("seq_dual.new_rd1", 32'(sb_rd_o1), 32'd8);
        check("seq_dual.new_rd2", 32'(sb_rd_o2), 32'd9);
        flush_i = 1'b1;
        #1;
        check("seq_flush.ready", 32'(pair_ready_o), 32'd0);
        check("seq_flush.issue", 32'(issue_v_o), 32'b11);
        tick();
        flush_i = 1'b0;
        #1;
        check("seq_flush.dual_cnt", dual_cnt_o, 32'd2);
        check("seq_flush.empty_rd1", 32'(sb_rd_o1), 32'd0);
        check("seq_flush.ready_after", 32'(pair_ready_o), 32'd1);

        // Intra-pair RAW: B shifts into A and issues next cycle
        do_reset();
        load_vec(1);
        exe_ready_i = 2'b11; sb_rs_match_i2 = 2'b01;
        #1;
        check("seq_raw.issue0", 32'(issue_v_o), 32'b01);
        tick();
        sb_rs_match_i2 = 2'b00;
        #1;
        $display("seq_raw: sb_rd1=%0d issue=%b", sb_rd_o1, issue_v_o);
        check("seq_raw.shift_rd1", 32'(sb_rd_o1), 32'd7);
        check("seq_raw.issue1", 32'(issue_v_o), 32'b01);
        check("seq_raw.ready1", 32'(pair_ready_o), 32'd1);
        tick();
        check("seq_raw.single_cnt", single_cnt_o, 32'd2);
        check("seq_raw.empty", 32'(sb_rd_o1), 32'd0);

        // Older RAW on A holds the pair for three cycles
        do_reset();
        load_vec(0);
        exe_ready_i = 2'b11; sb_rs_match_i1 = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("seq_old.stall_issue", 32'(issue_v_o), 32'd0);
            check("seq_old.stall_ready", 32'(pair_ready_o), 32'd0);
            tick();
        end
        sb_rs_match_i1 = 2'b00;
        #1;
        $display("seq_old: stall_cnt=%0d issue=%b", stall_cnt_o, issue_v_o);
        check("seq_old.stall_cnt", stall_cnt_o, 32'd3);
        check("seq_old.issue", 32'(issue_v_o), 32'b11);
        tick();
        check("seq_old.dual_cnt", dual_cnt_o, 32'd1);

        // Flush in TWO with both pipes blocked
        do_reset();
        load_vec(0);
        exe_ready_i = 2'b00; flush_i = 1'b1;
        #1;
        check("seq_flush2.ready", 32'(pair_ready_o), 32'd0);
        check("seq_flush2.issue", 32'(issue_v_o), 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        check("seq_flush2.empty_rd1", 32'(sb_rd_o1), 32'd0);
        check("seq_flush2.ready_after", 32'(pair_ready_o), 32'd1);
        check("seq_flush2.stall_cnt", stall_cnt_o, 32'd1);

        // Reset in the middle of a stall
        do_reset();
        load_vec(0);
        exe_ready_i = 2'b11; sb_rs_match_i1 = 2'b01;
        tick();
        tick();
        check("seq_rst.stall_before", stall_cnt_o, 32'd2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        sb_rs_match_i1 = 2'b00;
        #1;
        $display("seq_rst: stall_cnt=%0d ready=%b", stall_cnt_o, pair_ready_o);
        check("seq_rst.stall_cnt", stall_cnt_o, 32'd0);
        check("seq_rst.dual_cnt", dual_cnt_o, 32'd0);
        check("seq_rst.single_cnt", single_cnt_o, 32'd0);
        check("seq_rst.sb_rd1", 32'(sb_rd_o1), 32'd0);
        check("seq_rst.issue", 32'(issue_v_o), 32'd0);
        check("seq_rst.ready", 32'(pair_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/bp_be_dual_issue_scheduler.md
Name: bp_be_dual_issue_scheduler

Overview:
- In-order dual-issue scheduler between decode and the two execution pipes.
- Holds a decoded instruction pair in a 2-slot issue buffer and drives slot operands to the dual-port scoreboard.
- Uses the scoreboard RAW/WAW matches plus structural rules to issue 0, 1 or 2 instructions per cycle.
- Sets scoreboard bits for issued writers and keeps issue statistics.

Parameters:
- num_rs_p, 2, source operands per instruction.
- reg_addr_width_p, 5, register address width.
- cnt_width_p, 32, width of each statistics counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  drop all buffered instructions.
- pair_v_i  in  1  decoded pair valid.
- pair_ready_o  out  1  pair accepted when pair_v_i&pair_ready_o.
- instr_v_i  in  2  per-slot valid within the pair; [0] is older.
- rs_i  in  2 x num_rs_p x reg_addr_width_p  source registers.
- rs_used_i  in  2 x num_rs_p  source actually read.
- rd_i  in  2 x reg_addr_width_p  destination register.
- rd_w_v_i  in  2  writes rd.
- is_mem_i  in  2  load/store.
- is_ctrl_i  in  2  branch/jump/csr.
- exe_ready_i  in  2  pipe k can accept an instruction.
- sb_rs_o1, sb_rs_o2  out  num_rs_p x reg_addr_width_p  sources of slot A / slot B.
- sb_rd_o1, sb_rd_o2  out  reg_addr_width_p  destinations of slot A / slot B.
- sb_rs_match_i1, sb_rs_match_i2  in  num_rs_p  scoreboard RAW flags.
- sb_rd_match_i1, sb_rd_match_i2  in  1  scoreboard WAW flags.
- score_v_o  out  2  set scoreboard bit for issued writer k.
- score_rd_o  out  2 x reg_addr_width_p  register to score.
- issue_v_o  out  2  slot A to pipe 0, slot B to pipe 1.
- issue_slot_idx_o  out  2  buffer index of each issued instruction (debug).
- dual_cnt_o, single_cnt_o, stall_cnt_o  out  cnt_width_p  statistics.

Behaviour:
- State: count_r in {EMPTY=0, ONE=1, TWO=2}; slots A (older) and B.
- EMPTY holds no A or B. ONE holds only A valid. TWO holds A and B.
- sb_rd_o1 = A.rd if A valid and A.rd_w_v and A.rd!=0, else 0. Same rule for slot B on sb_rd_o2.
- RAW hazard for slot k requires all of: slot valid, rs_used, rs!=0, and sb_rs_match.
- WAW hazard for slot k requires all of: rd_w_v, rd!=0, and sb_rd_match.
- x0 never hazards and is never scored.
- issueA = A valid & no hazard(A) & exe_ready_i[0].
- issueB = issueA & B valid & no hazard(B) & exe_ready_i[1] & ~(A.is_mem & B.is_mem) & ~A.is_ctrl.
- Issue is strictly in order: B never issues without A.
- issue_v_o = {issueB, issueA}.
- score_v_o[k] = issue[k] & rd_w_v & rd!=0, with score_rd_o[k] = slot rd. All issue and score outputs are combinational, same cycle.
- Next state without flush:
  - TWO with A and B issued -> EMPTY.
  - TWO with only A issued -> ONE; B shifts into A.
  - ONE with A issued -> EMPTY.
  - No issue -> hold.
- pair_ready_o = ~flush_i & (count_r==EMPTY | every valid slot issues this cycle).
- On accept, instr_v_i selects the load:
  - 2'b11 -> TWO.
  - 2'b01 -> ONE.
  - 2'b10 -> ONE, with slot 1 loaded into A.
  - 2'b00 is accepted and dropped.
- Accept and drain in the same cycle: the new pair overwrites the buffer.
- flush_i: next state EMPTY, and pair_ready_o=0.
- Instructions issued in the flush cycle still issue; upstream squashes them.
- Counters increment once per cycle while count_r!=EMPTY:
  - dual_cnt on 2 issued.
  - single_cnt on 1 issued.
  - stall_cnt on 0 issued.
- Counters saturate at all-ones and are not cleared by flush.
- Reset: count_r=EMPTY; all counters 0; issue_v_o=0; score_v_o=0; pair_ready_o=1 in the first post-reset cycle with flush_i=0; sb_rd_o1/2 and sb_rs_o1/2 = 0.

Test Plan:
- Independent pair: add x1,x2,x3 / add x4,x5,x6, scoreboard clear, both pipes ready.
  - Same cycle: issue_v_o=2'b11, score_rd_o={4,1}, pair_ready_o=1.
  - Next cycle: dual_cnt=1.
- Intra-pair RAW: add x1 / add x7,x1,x2.
  - sb_rs_match_i2[0]=1 -> issue_v_o=2'b01, then count_r=ONE with B in A.
  - Next cycle: sb_rd_o1=7, and 2'b01 when clear.
- Old RAW: A reads x9 with sb_rs_match_i1[0]=1 for 3 cycles.
  - No issue for 3 cycles; stall_cnt=3; pair_ready_o=0.
  - 4th cycle: 2'b11.
- Structural rules:
  - Two loads -> 2'b01 only.
  - Branch in A with ALU in B -> 2'b01.
  - exe_ready_i=2'b01 -> 2'b01.
- x0 handling: rd=x0 and rs=x0 in both slots -> score_v_o=0, 2'b11 despite a spurious rs0==rd0 match.
- Flush and reset:
  - Flush in state TWO with exe_ready_i=0 -> EMPTY next cycle; pair_ready_o=0 during the flush cycle.
  - Reset mid-stall -> counters 0 and EMPTY.
